cond_exec_unit: RTL

COND_EXEC_UNIT -- requirements
Module: cond_exec_unit

---
 rtl/cond_pkg.sv | 43 ++++
 rtl/cond_eval.sv | 44 ++++
 rtl/cond_exec_unit.sv | 77 +++++++
 3 files changed

// File: rtl/cond_pkg.sv
// Shared types for the conditional-execution unit: condition codes,
// flag bit positions and the IT-block state register.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_t;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    // [7:4] current condition, [3:0] remaining-instruction mask
    typedef logic [7:0] itstate_t;

    function automatic itstate_t it_advance(input itstate_t st);
        itstate_t nxt;
        nxt = st;
        if (st[2:0] == 3'b000) begin
            nxt = '0;
        end else begin
            nxt[4:0] = {st[3:0], 1'b0};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational evaluation of one 4-bit condition code against
// the [Z,C,N,V] flags.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       result
);

    logic z;
    logic c;
    logic n;
    logic v;

    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign n = flags[FLAG_N];
    assign v = flags[FLAG_V];

    always_comb begin
        result = 1'b0;
        case (cond_t'(cond))
            EQ: result = z;
            NE: result = !z;
            CS: result = c;
            CC: result = !c;
            MI: result = n;
            PL: result = !n;
            VS: result = v;
            VC: result = !v;
            HI: result = c && !z;
            LS: result = !c || z;
            GE: result = (n == v);
            LT: result = (n != v);
            GT: result = !z && (n == v);
            LE: result = z || (n != v);
            AL: result = 1'b1;
            NV: result = 1'b0;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_exec_unit.sv
// Flag register, IT-block sequencer and per-lane condition evaluation
// with registered pass/pass_valid outputs.
module cond_exec_unit
    import cond_pkg::*;
#(
    parameter int LANES       = 2,
    parameter bit FLAG_BYPASS = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flags_we,
    input  logic [3:0]         flags_in,
    input  logic [LANES-1:0]   cond_valid,
    input  logic [4*LANES-1:0] cond,
    input  logic               it_start,
    input  logic [3:0]         it_firstcond,
    input  logic [3:0]         it_mask,
    input  logic               instr_adv,
    output logic [3:0]         flags_out,
    output logic [LANES-1:0]   pass,
    output logic [LANES-1:0]   pass_valid,
    output logic               in_it,
    output logic               it_err
);

    logic [3:0]       flags_q;
    logic [3:0]       eval_flags;
    itstate_t         it_state;
    logic [LANES-1:0] res;
    logic             start_ok;
    logic             start_bad;

    assign flags_out  = flags_q;
    assign in_it      = (it_state[3:0] != 4'b0000);
    assign eval_flags = (FLAG_BYPASS && flags_we) ? flags_in : flags_q;

    assign start_ok  = it_start && !in_it && (it_mask != 4'b0000);
    assign start_bad = it_start && (in_it || (it_mask == 4'b0000));

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [3:0] lane_cond;
        // only lane 0 is steered by the IT block
        if (i == 0) begin : g_it
            assign lane_cond = in_it ? it_state[7:4] : cond[3:0];
        end else begin : g_own
            assign lane_cond = cond[4*i +: 4];
        end
        cond_eval u_eval (
            .cond   (lane_cond),
            .flags  (eval_flags),
            .result (res[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q    <= '0;
            it_state   <= '0;
            pass       <= '0;
            pass_valid <= '0;
            it_err     <= 1'b0;
        end else begin
            if (flags_we) begin
                flags_q <= flags_in;
            end
            pass       <= cond_valid & res;
            pass_valid <= cond_valid;
            it_err     <= start_bad;
            if (start_ok) begin
                it_state <= {it_firstcond, it_mask};
            end else if (instr_adv && in_it) begin
                it_state <= it_advance(it_state);
            end
        end
    end

endmodule
